// File: rtl/seq_demux_decoder_pkg.sv
// Shared encodings for the sequenced demux/decoder: operating modes and scan FSM states.
package seq_demux_decoder_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_LATCH = 2'b10,
        MODE_SCAN  = 2'b11
    } mode_e;

    typedef enum logic {
        SCAN_IDLE  = 1'b0,
        SCAN_DWELL = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seq_demux_decoder_onehot_decoder.sv
// Purely combinational binary-to-one-hot decoder: onehot = 1 << sel.
module onehot_decoder #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] onehot
);

    // Set exactly the bit addressed by sel.
    always_comb begin
        onehot      = {(1<<SEL_W){1'b0}};
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/seq_demux_decoder.sv
// Registered one-hot channel decoder with data routing and pulse, latch and auto-scan modes.
module seq_demux_decoder
    import seq_demux_decoder_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DATA_W  = 8,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DATA_W-1:0]     din,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      y_idx,
    output logic [DATA_W-1:0]     y_data,
    output logic                  y_valid,
    output logic                  scan_wrap
);

    localparam int NCH = 1 << SEL_W;

    mode_e              mode_q_r;
    scan_state_e        state_r;
    logic [SEL_W-1:0]   scan_idx_r;
    logic [DWELL_W-1:0] dwell_cnt_r;

    logic [SEL_W-1:0]   scan_next_s;
    logic [SEL_W-1:0]   dec_sel_s;
    logic [NCH-1:0]     dec_s;
    logic               mode_chg_s;

    // Next scan channel and decoder source; >= lets a shrunk dwell advance immediately.
    always_comb begin
        scan_next_s = scan_idx_r;
        if (state_r == SCAN_IDLE) begin
            scan_next_s = {SEL_W{1'b0}};
        end else if (dwell_cnt_r >= dwell) begin
            scan_next_s = scan_idx_r + SEL_W'(1'b1);
        end else begin
            scan_next_s = scan_idx_r;
        end

        if (mode_q_r == MODE_SCAN) begin
            dec_sel_s = scan_next_s;
        end else begin
            dec_sel_s = sel;
        end

        mode_chg_s = (mode != mode_q_r);
    end

    onehot_decoder #(.SEL_W(SEL_W)) u_onehot_decoder (
        .sel    (dec_sel_s),
        .onehot (dec_s)
    );

    // Mode tracking, scan FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q_r    <= MODE_OFF;
            state_r     <= SCAN_IDLE;
            scan_idx_r  <= {SEL_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
            y           <= {NCH{1'b0}};
            y_idx       <= {SEL_W{1'b0}};
            y_data      <= {DATA_W{1'b0}};
            y_valid     <= 1'b0;
            scan_wrap   <= 1'b0;
        end else if (mode_chg_s) begin
            // A mode switch blanks the outputs for one cycle; y_idx/y_data keep their last value.
            mode_q_r    <= mode_e'(mode);
            state_r     <= SCAN_IDLE;
            scan_idx_r  <= {SEL_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
            y           <= {NCH{1'b0}};
            y_valid     <= 1'b0;
            scan_wrap   <= 1'b0;
        end else begin
            scan_wrap <= 1'b0;
            case (mode_q_r)
                MODE_OFF: begin
                    y       <= {NCH{1'b0}};
                    y_valid <= 1'b0;
                end
                MODE_PULSE: begin
                    if (in_valid) begin
                        y       <= dec_s;
                        y_idx   <= sel;
                        y_data  <= din;
                        y_valid <= 1'b1;
                    end else begin
                        y       <= {NCH{1'b0}};
                        y_valid <= 1'b0;
                    end
                end
                MODE_LATCH: begin
                    if (in_valid) begin
                        y       <= dec_s;
                        y_idx   <= sel;
                        y_data  <= din;
                        y_valid <= 1'b1;
                    end else begin
                        y       <= y;
                        y_valid <= y_valid;
                    end
                end
                MODE_SCAN: begin
                    y          <= dec_s;
                    y_idx      <= scan_next_s;
                    y_data     <= din;
                    y_valid    <= 1'b1;
                    scan_idx_r <= scan_next_s;
                    case (state_r)
                        SCAN_IDLE: begin
                            state_r     <= SCAN_DWELL;
                            dwell_cnt_r <= {DWELL_W{1'b0}};
                        end
                        SCAN_DWELL: begin
                            if (dwell_cnt_r >= dwell) begin
                                dwell_cnt_r <= {DWELL_W{1'b0}};
                                scan_wrap   <= (scan_next_s == {SEL_W{1'b0}});
                            end else begin
                                dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1'b1);
                            end
                        end
                        default: begin
                            state_r <= SCAN_IDLE;
                        end
                    endcase
                end
                default: begin
                    y       <= {NCH{1'b0}};
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
